// File: rtl/char_jump_sequencer.sv
// Player sprite motion sequencer: run / crouch / airborne / land phases with a per-frame gravity integrator.
// Define JUMP_BUFFER_EN to remember a jump press made while falling or landing and replay it on return to RUN.
module char_jump_sequencer #(
    parameter int RUN_DIV       = 10000000,
    parameter int RUN_FRAMES    = 6,
    parameter int CROUCH_FRAMES = 5,
    parameter int LAND_FRAMES   = 5,
    parameter int V0            = 22,
    parameter int GRAV          = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        jump_key,
    output logic [8:0]  y_offset,
    output logic        anim_sel,
    output logic [2:0]  anim_frame,
    output logic        airborne,
    output logic        busy
);
    typedef enum logic [1:0] {RUN, CROUCH, AIR, LAND} state_t;

    localparam int RUN_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

    state_t             state;
    state_t             state_nx;
    logic [RUN_W-1:0]   run_cnt;
    logic [2:0]         run_frame;
    logic [7:0]         crouch_cnt;
    logic [7:0]         crouch_nx;
    logic [7:0]         land_cnt;
    logic [7:0]         land_nx;
    logic signed [10:0] vel;
    logic signed [10:0] vel_nx;
    logic signed [10:0] next_y;
    logic [8:0]         y_nx;
    logic               sel_nx;
    logic [2:0]         frame_nx;
    logic               air_nx;
    logic               busy_nx;
    logic               pix_origin;
    logic               pix_origin_d;
    logic               frame_tick;
    logic               jump_pending;

    // The origin pixel may last several clocks; only its first clock counts as the frame tick.
    assign pix_origin = (display_col == 12'd0) && (display_row == 11'd0);
    assign frame_tick = pix_origin && !pix_origin_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_origin_d <= 1'b0;
        end else begin
            pix_origin_d <= pix_origin;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_cnt   <= '0;
            run_frame <= 3'd0;
        end else if (run_cnt == RUN_W'(RUN_DIV - 1)) begin
            run_cnt   <= '0;
            run_frame <= (run_frame == 3'(RUN_FRAMES - 1)) ? 3'd0 : run_frame + 3'd1;
        end else begin
            run_cnt <= run_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx  = state;
        y_nx      = y_offset;
        vel_nx    = vel;
        crouch_nx = crouch_cnt;
        land_nx   = land_cnt;
        next_y    = $signed({2'b00, y_offset}) + vel;
        case (state)
            RUN: begin
                if (jump_key || jump_pending) begin
                    state_nx  = CROUCH;
                    crouch_nx = 8'd0;
                end
            end
            CROUCH: begin
                if (crouch_cnt == 8'(CROUCH_FRAMES - 1)) begin
                    state_nx = AIR;
                    y_nx     = 9'd0;
                    vel_nx   = 11'(V0);
                end else begin
                    crouch_nx = crouch_cnt + 8'd1;
                end
            end
            AIR: begin
                // Touchdown clamps to the ground instead of letting the sum go negative.
                if ((vel < 11'sd0) && (next_y <= 11'sd0)) begin
                    state_nx = LAND;
                    y_nx     = 9'd0;
                    land_nx  = 8'd0;
                end else begin
                    y_nx   = next_y[8:0];
                    vel_nx = vel - $signed(11'(GRAV));
                end
            end
            default: begin
                if (land_cnt == 8'(LAND_FRAMES - 1)) begin
                    state_nx = RUN;
                end else begin
                    land_nx = land_cnt + 8'd1;
                end
            end
        endcase

        sel_nx   = 1'b1;
        frame_nx = run_frame;
        air_nx   = (state_nx == AIR);
        busy_nx  = (state_nx != RUN);
        case (state_nx)
            RUN:     sel_nx = 1'b0;
            CROUCH:  frame_nx = (crouch_nx < 8'(CROUCH_FRAMES / 2)) ? 3'd1 : 3'd2;
            AIR:     frame_nx = (vel_nx > 11'sd0) ? 3'd3 : 3'd4;
            default: frame_nx = (land_nx == 8'(LAND_FRAMES - 1)) ? 3'd7 : 3'd6;
        endcase
    end

`ifdef JUMP_BUFFER_EN
    logic jump_key_d;

    // Presses made while descending or landing are held until the next RUN tick consumes them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jump_key_d   <= 1'b0;
            jump_pending <= 1'b0;
        end else begin
            jump_key_d <= jump_key;
            if (frame_tick && (state == RUN) && (state_nx == CROUCH)) begin
                jump_pending <= 1'b0;
            end else if (jump_key && !jump_key_d &&
                         (((state == AIR) && (vel <= 11'sd0)) || (state == LAND))) begin
                jump_pending <= 1'b1;
            end
        end
    end
`else
    assign jump_pending = 1'b0;
`endif

    // Everything the renderer sees changes only on the frame tick, so a frame never tears.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            y_offset   <= 9'd0;
            vel        <= 11'sd0;
            crouch_cnt <= 8'd0;
            land_cnt   <= 8'd0;
            anim_sel   <= 1'b0;
            anim_frame <= 3'd0;
            airborne   <= 1'b0;
            busy       <= 1'b0;
        end else if (frame_tick) begin
            state      <= state_nx;
            y_offset   <= y_nx;
            vel        <= vel_nx;
            crouch_cnt <= crouch_nx;
            land_cnt   <= land_nx;
            anim_sel   <= sel_nx;
            anim_frame <= frame_nx;
            airborne   <= air_nx;
            busy       <= busy_nx;
        end
    end
endmodule

// File: tb/tb_char_jump_sequencer.sv
// Randomised bench for char_jump_sequencer: each jump is expanded into its whole expected output script.
// Builds with or without JUMP_BUFFER_EN; the reference follows the same macro.
module tb_char_jump_sequencer;
    localparam int RUN_DIV       = 4;
    localparam int RUN_FRAMES    = 6;
    localparam int CROUCH_FRAMES = 5;
    localparam int LAND_FRAMES   = 5;
    localparam int V0            = 22;
    localparam int GRAV          = 1;
    localparam int NUM_FRAMES    = 700;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] display_col;
    logic [10:0] display_row;
    logic        jump_key;
    logic [8:0]  y_offset;
    logic        anim_sel;
    logic [2:0]  anim_frame;
    logic        airborne;
    logic        busy;

    char_jump_sequencer #(
        .RUN_DIV(RUN_DIV), .RUN_FRAMES(RUN_FRAMES), .CROUCH_FRAMES(CROUCH_FRAMES),
        .LAND_FRAMES(LAND_FRAMES), .V0(V0), .GRAV(GRAV)
    ) dut (
        .clock(clock), .reset(reset), .display_col(display_col), .display_row(display_row),
        .jump_key(jump_key), .y_offset(y_offset), .anim_sel(anim_sel), .anim_frame(anim_frame),
        .airborne(airborne), .busy(busy)
    );

    always #5 clock = ~clock;

    // Clock edges since reset release; the run frame is a plain function of this count.
    int edge_count;
    always @(posedge clock or posedge reset) begin
        if (reset) edge_count <= 0;
        else       edge_count <= edge_count + 1;
    end

    typedef struct {
        int y; int sel; int frame; int air; int busy; bit bufok; bit is_run;
    } step_t;

    step_t plan[$];
    step_t cur;
    bit    pending;
    int    errors = 0;
    int    checks = 0;
    int    resets_done = 0;
    int    frame_no;

    function automatic step_t mkStep(int y, int sel, int frame, int air, int bsy, bit bufok, bit is_run);
        step_t s;
        s.y = y; s.sel = sel; s.frame = frame; s.air = air; s.busy = bsy;
        s.bufok = bufok; s.is_run = is_run;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s frame=%0d got=%0d expected=%0d", tag, frame_no, actual, expected);
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".y_offset"},   int'(y_offset),   cur.y);
        checkOutput({tag, ".anim_sel"},   int'(anim_sel),   cur.sel);
        checkOutput({tag, ".anim_frame"}, int'(anim_frame), cur.frame);
        checkOutput({tag, ".airborne"},   int'(airborne),   cur.air);
        checkOutput({tag, ".busy"},       int'(busy),       cur.busy);
    endtask

    // Whole jump as the renderer should see it, one entry per frame tick.
    task automatic buildJump();
        int y;
        int v;
        for (int c = 0; c < CROUCH_FRAMES; c++)
            plan.push_back(mkStep(0, 1, (c < CROUCH_FRAMES / 2) ? 1 : 2, 0, 1, 0, 0));
        plan.push_back(mkStep(0, 1, 3, 1, 1, 0, 0));
        y = 0;
        v = V0;
        while (!(v < 0 && y + v <= 0)) begin
            y = y + v;
            v = v - GRAV;
            plan.push_back(mkStep(y, 1, (v > 0) ? 3 : 4, 1, 1, v <= 0, 0));
        end
        for (int l = 0; l < LAND_FRAMES; l++)
            plan.push_back(mkStep(0, 1, (l == LAND_FRAMES - 1) ? 7 : 6, 0, 1, 1, 0));
        plan.push_back(mkStep(0, 0, 0, 0, 0, 0, 1));
    endtask

    task automatic modelReset();
        plan.delete();
        pending = 1'b0;
        cur = mkStep(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic modelTick();
        if (plan.size() > 0) begin
            cur = plan.pop_front();
        end else if (jump_key || pending) begin
            pending = 1'b0;
            buildJump();
            cur = plan.pop_front();
        end else begin
            cur = mkStep(0, 0, 0, 0, 0, 0, 1);
        end
        if (cur.is_run) cur.frame = ((edge_count - 1) / RUN_DIV) % RUN_FRAMES;
    endtask

    task automatic setJump(input logic v);
`ifdef JUMP_BUFFER_EN
        if (v && !jump_key && cur.bufok) pending = 1'b1;
`endif
        jump_key = v;
    endtask

    task automatic doReset();
        #2 reset = 1'b1;
        #1 modelReset();
        compareAll("rst_async");
        resets_done++;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1 compareAll("rst_release");
    endtask

    // One video frame: origin pixel held for 'hold' clocks, then 'gap' clocks elsewhere.
    task automatic applyStimulus(input int hold, input int gap, input logic jk, input bit mid);
        @(negedge clock);
        display_col = 12'd0;
        display_row = 11'd0;
        if (!mid) setJump(jk);
        @(posedge clock);
        #1 modelTick();
        compareAll("tick");
        for (int i = 1; i < hold; i++) @(negedge clock);
        @(negedge clock);
        display_col = 12'($urandom_range(0, 639));
        display_row = 11'($urandom_range(1, 479));
        for (int i = 1; i < gap; i++) begin
            @(negedge clock);
            if (i == 1 && cur.air == 1 && cur.y > 100 &&
                ((frame_no >= 200 && resets_done == 0) || $urandom_range(0, 24) == 0))
                doReset();
            if (mid && i == 1) setJump(jk);
        end
        compareAll("hold");
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic jk;
        int   r;
        reset       = 1'b1;
        jump_key    = 1'b0;
        display_col = 12'd5;
        display_row = 11'd5;
        frame_no    = 0;
        modelReset();
        #12 compareAll("rst_init");
        @(negedge clock);
        reset = 1'b0;

        // Directed opening: a single-frame press, then the full jump with the key released.
        applyStimulus(2, 4, 1'b1, 1'b0);
        jk = 1'b0;
        for (frame_no = 1; frame_no < NUM_FRAMES; frame_no++) begin
            if (frame_no < 70) begin
                jk = 1'b0;
            end else begin
                r = $urandom_range(0, 9);
                if (r >= 8)      jk = 1'b1;
                else if (r >= 5) jk = 1'b0;
            end
            applyStimulus($urandom_range(1, 4), $urandom_range(2, 6), jk, bit'($urandom_range(0, 1)));
        end
        checkOutput("reset_seen", resets_done > 0 ? 1 : 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
